cc_refill_writer: RTL and testbench

Cache-line refill engine for the cache controller, the write side of the tag/data SRAMs that the tag comparison stage reads. On a miss it fetches the 64-byte line from memory with one AXI4 INCR read burst and assembles the eight 64-bit beats. It then writes the full line into the data SRAM and `{valid=1, tag}` into the tag SRAM at the missed index, so the replayed request hits. Address split is tag[31:15], index[14:6], offset[5:0].

---
 rtl/cc_refill_writer.sv | 137 +++++++++++++
 tb/tb_cc_refill_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_refill_writer.sv
// Cache-line refill engine: fetches one 64-byte line with an AXI4 INCR burst
// and writes it, with its tag, into the data/tag SRAMs at the missed index.
module cc_refill_writer #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_i,
    input  logic [16:0]               tag_i,
    input  logic [8:0]                index_i,
    output logic                      busy_o,
    output logic [31:0]               araddr_o,
    output logic [3:0]                arlen_o,
    output logic [2:0]                arsize_o,
    output logic [1:0]                arburst_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,
    input  logic [DATA_W-1:0]         rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o,
    output logic                      data_wren_o,
    output logic [8:0]                data_waddr_o,
    output logic [DATA_W*BEATS-1:0]   data_wdata_o,
    output logic                      tag_wren_o,
    output logic [8:0]                tag_waddr_o,
    output logic [17:0]               tag_wdata_o,
    output logic                      fill_done_o,
    output logic                      fill_err_o
);

    localparam logic [2:0] LAST_CNT = 3'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [16:0]       tag_q;
    logic [8:0]        idx_q;
    logic [2:0]        cnt_q;
    logic              err_q;
    logic              extra_q;
    logic [DATA_W-1:0] line_q [BEATS];

    logic beat_ok;
    logic beat_bad;

    assign beat_ok  = (state_q == RECV) && rvalid_i;
    assign beat_bad = (rresp_i != 2'b00)
                    || (rlast_i && (cnt_q != LAST_CNT))
                    || (!rlast_i && (cnt_q == LAST_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss_i)              state_d = REQ;
            REQ:     if (arready_i)           state_d = RECV;
            RECV:    if (rvalid_i && rlast_i) state_d = WRITE;
            WRITE:                            state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = 1'b0;
        arvalid_o   = 1'b0;
        rready_o    = 1'b0;
        data_wren_o = 1'b0;
        tag_wren_o  = 1'b0;
        fill_done_o = 1'b0;
        fill_err_o  = 1'b0;
        unique case (state_q)
            IDLE: ;
            REQ: begin
                busy_o    = 1'b1;
                arvalid_o = 1'b1;
            end
            RECV: begin
                busy_o   = 1'b1;
                rready_o = 1'b1;
            end
            WRITE: begin
                busy_o      = 1'b1;
                fill_done_o = 1'b1;
                fill_err_o  = err_q;
                data_wren_o = !err_q;
                tag_wren_o  = !err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            extra_q <= 1'b0;
        end else if ((state_q == IDLE) && miss_i) begin
            tag_q   <= tag_i;
            idx_q   <= index_i;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            extra_q <= 1'b0;
        end else if (beat_ok) begin
            if (cnt_q != LAST_CNT) cnt_q <= cnt_q + 3'd1;
            if (beat_bad) err_q <= 1'b1;
            if ((cnt_q == LAST_CNT) && !rlast_i) extra_q <= 1'b1;
        end
    end

    // Beats past the last slot are consumed but never overwrite slot 7.
    always_ff @(posedge clk) begin
        if (beat_ok && !extra_q) line_q[cnt_q] <= rdata_i;
    end

    for (genvar k = 0; k < BEATS; k++) begin : g_line
        assign data_wdata_o[k*DATA_W +: DATA_W] = line_q[k];
    end

    assign araddr_o     = {tag_q, idx_q, 6'b0};
    assign arlen_o      = 4'd7;
    assign arsize_o     = 3'd3;
    assign arburst_o    = 2'b01;
    assign data_waddr_o = idx_q;
    assign tag_waddr_o  = idx_q;
    assign tag_wdata_o  = {1'b1, tag_q};

endmodule

// File: tb/tb_cc_refill_writer.sv
// Directed bench for cc_refill_writer: clean, backpressure, error,
// miss-while-busy and mid-refill reset scenarios.
module tb_cc_refill_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_i;
    logic [16:0]  tag_i;
    logic [8:0]   index_i;
    logic         busy_o;
    logic [31:0]  araddr_o;
    logic [3:0]   arlen_o;
    logic [2:0]   arsize_o;
    logic [1:0]   arburst_o;
    logic         arvalid_o;
    logic         arready_i;
    logic [63:0]  rdata_i;
    logic [1:0]   rresp_i;
    logic         rlast_i;
    logic         rvalid_i;
    logic         rready_o;
    logic         data_wren_o;
    logic [8:0]   data_waddr_o;
    logic [511:0] data_wdata_o;
    logic         tag_wren_o;
    logic [8:0]   tag_waddr_o;
    logic [17:0]  tag_wdata_o;
    logic         fill_done_o;
    logic         fill_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;

    cc_refill_writer #(.DATA_W(64), .BEATS(8)) dut (
        .clk(clk), .rst(rst), .miss_i(miss_i), .tag_i(tag_i),
        .index_i(index_i), .busy_o(busy_o), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o), .data_wren_o(data_wren_o),
        .data_waddr_o(data_waddr_o), .data_wdata_o(data_wdata_o),
        .tag_wren_o(tag_wren_o), .tag_waddr_o(tag_waddr_o),
        .tag_wdata_o(tag_wdata_o), .fill_done_o(fill_done_o),
        .fill_err_o(fill_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (fill_done_o) done_cnt <= done_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = base | 64'(k);
        return l;
    endfunction

    task automatic beat(input logic [63:0] d, input logic [1:0] resp,
                        input logic last);
        rvalid_i = 1'b1;
        rdata_i  = d;
        rresp_i  = resp;
        rlast_i  = last;
        tick();
        rvalid_i = 1'b0;
        rresp_i  = 2'b00;
        rlast_i  = 1'b0;
    endtask

    task automatic start(input logic [16:0] t, input logic [8:0] i);
        miss_i  = 1'b1;
        tag_i   = t;
        index_i = i;
        tick();
        miss_i = 1'b0;
    endtask

    task automatic accept();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
    endtask

    localparam logic [63:0] BASE_A = 64'h1111_0000_0000_0000;
    localparam logic [63:0] BASE_B = 64'hA5A5_0000_0000_0000;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int d0;
        logic [511:0] line_a;
        logic [31:0]  addr;
        line_a = mk_line(BASE_A);

        rst = 1'b1; miss_i = 0; tag_i = 0; index_i = 0;
        arready_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 0; rvalid_i = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy",    busy_o, 0);
        chk("rst_ctrl",    {arvalid_o, rready_o, data_wren_o, tag_wren_o,
                            fill_done_o, fill_err_o}, 0);
        chk("rst_araddr",  araddr_o, 0);
        chk("rst_consts",  {arlen_o, arsize_o, arburst_o},
                           {4'd7, 3'd3, 2'b01});
        rst = 1'b0;
        tick();

        // Clean refill, minimum latency
        c0 = cyc;
        start(17'h1A5A5, 9'h0C3);
        chk("c_arvalid", arvalid_o, 1);
        chk("c_busy",    busy_o, 1);
        chk("c_araddr",  araddr_o, 32'hD2D2_B0C0);
        chk("c_rready0", rready_o, 0);
        accept();
        chk("c_rready",  rready_o, 1);
        chk("c_arv_lo",  arvalid_o, 0);
        for (int k = 0; k < 8; k++) beat(BASE_A | 64'(k), 2'b00, k == 7);
        chk("c_lat",     cyc - c0, 10);
        chk("c_wren",    {data_wren_o, tag_wren_o}, 2'b11);
        chk("c_daddr",   data_waddr_o, 9'h0C3);
        chk("c_taddr",   tag_waddr_o, 9'h0C3);
        chk("c_tdata",   tag_wdata_o, 18'h3A5A5);
        chk("c_line",    data_wdata_o, line_a);
        chk("c_done",    {fill_done_o, fill_err_o}, 2'b10);
        chk("c_rready_w", rready_o, 0);
        tick();
        chk("c_idle",    {busy_o, fill_done_o, data_wren_o}, 0);

        // Backpressure on AR and R
        c0 = cyc;
        start(17'h1A5A5, 9'h0C3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", arvalid_o, 1);
            chk("bp_araddr",  araddr_o, 32'hD2D2_B0C0);
            tick();
        end
        accept();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bp_gap_ready", rready_o, 1);
            beat(BASE_A | 64'(k), 2'b00, k == 7);
        end
        chk("bp_lat",  cyc - c0, 10 + 5 + 8);
        chk("bp_line", data_wdata_o, line_a);
        chk("bp_done", {fill_done_o, fill_err_o, data_wren_o}, 3'b101);
        tick();

        // Slave error on beat 3
        start(17'h00001, 9'h002);
        accept();
        for (int k = 0; k < 8; k++)
            beat(BASE_B | 64'(k), (k == 3) ? 2'b10 : 2'b00, k == 7);
        chk("se_wren", {data_wren_o, tag_wren_o}, 2'b00);
        chk("se_done", {fill_done_o, fill_err_o}, 2'b11);
        tick();
        chk("se_after", {fill_done_o, fill_err_o, busy_o}, 0);

        // Early rlast on beat 5
        start(17'h00002, 9'h004);
        accept();
        for (int k = 0; k < 6; k++) beat(BASE_B | 64'(k), 2'b00, k == 5);
        chk("er_done", {fill_done_o, fill_err_o}, 2'b11);
        chk("er_wren", {data_wren_o, tag_wren_o}, 2'b00);
        tick();

        // Late rlast on beat 10
        start(17'h00003, 9'h006);
        accept();
        for (int k = 0; k < 10; k++) beat(BASE_B | 64'(k), 2'b00, 1'b0);
        chk("lr_still_recv", {rready_o, fill_done_o}, 2'b10);
        beat(BASE_B | 64'd10, 2'b00, 1'b1);
        chk("lr_done", {fill_done_o, fill_err_o}, 2'b11);
        chk("lr_wren", {data_wren_o, tag_wren_o}, 2'b00);
        tick();

        // Miss while busy is ignored
        d0 = done_cnt;
        addr = {17'h00F0F, 9'h1FF, 6'b0};
        start(17'h00F0F, 9'h1FF);
        accept();
        for (int k = 0; k < 8; k++) begin
            miss_i  = (k == 3);
            tag_i   = 17'h1FFFF;
            index_i = 9'h000;
            beat(BASE_A | 64'(k), 2'b00, k == 7);
            miss_i = 1'b0;
        end
        chk("mb_araddr", araddr_o, addr);
        chk("mb_tdata",  tag_wdata_o, {1'b1, 17'h00F0F});
        chk("mb_daddr",  data_waddr_o, 9'h1FF);
        chk("mb_wren",   {data_wren_o, fill_err_o}, 2'b10);
        repeat (3) tick();
        chk("mb_single", done_cnt - d0, 1);
        chk("mb_idle",   busy_o, 0);

        // Reset during beat 4
        d0 = done_cnt;
        start(17'h01234, 9'h055);
        accept();
        for (int k = 0; k < 4; k++) beat(BASE_B | 64'(k), 2'b00, 1'b0);
        rvalid_i = 1'b1;
        rdata_i  = BASE_B | 64'd4;
        #1 rst = 1'b1;
        #1;
        chk("rr_ctrl", {busy_o, arvalid_o, rready_o, data_wren_o,
                        tag_wren_o, fill_done_o, fill_err_o}, 0);
        chk("rr_araddr", araddr_o, 0);
        rvalid_i = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("rr_nodone", done_cnt - d0, 0);

        c0 = cyc;
        start(17'h0ABCD, 9'h123);
        chk("rr2_araddr", araddr_o, {17'h0ABCD, 9'h123, 6'b0});
        accept();
        for (int k = 0; k < 8; k++) beat(BASE_B | 64'(k), 2'b00, k == 7);
        chk("rr2_lat",  cyc - c0, 10);
        chk("rr2_wren", {data_wren_o, tag_wren_o, fill_err_o}, 3'b110);
        chk("rr2_tdata", tag_wdata_o, {1'b1, 17'h0ABCD});
        chk("rr2_line", data_wdata_o, mk_line(BASE_B));
        tick();
        chk("rr2_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
